// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : E-stage multiply/divide unit owning HI/LO; busy stalls dependents.
// Revision : 1.0
// ============================================================================
module md_unit #(
    parameter int MULT_LATENCY = 5,
    parameter int DIV_LATENCY  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_LATENCY);
    localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_a_mag, w_b_mag, w_sdivisor, w_udivisor;
    logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr;
    logic [31:0] w_uq, w_ur;

    // Signed division works on magnitudes so 0x80000000 / -1 needs no special
    // case: the magnitude quotient 0x80000000 is already the required result.
    always_comb begin
        w_smul     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        w_umul     = {32'd0, a} * {32'd0, b};
        w_a_mag    = a[31] ? (32'd0 - a) : a;
        w_b_mag    = b[31] ? (32'd0 - b) : b;
        w_sdivisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_udivisor = (b == 32'd0) ? 32'd1 : b;
        w_sq_mag   = w_a_mag / w_sdivisor;
        w_sr_mag   = w_a_mag % w_sdivisor;
        w_sq       = (a[31] ^ b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
        w_sr       = a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
        w_uq       = a / w_udivisor;
        w_ur       = a % w_udivisor;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {phi_d, plo_d} = w_smul;
                            cnt_d   = C_MULT_CNT;
                            state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            {phi_d, plo_d} = w_umul;
                            cnt_d   = C_MULT_CNT;
                            state_d = S_BUSY;
                        end
                        OP_DIV: begin
                            phi_d   = (b == 32'd0) ? a : w_sr;
                            plo_d   = (b == 32'd0) ? 32'hFFFF_FFFF : w_sq;
                            cnt_d   = C_DIV_CNT;
                            state_d = S_BUSY;
                        end
                        OP_DIVU: begin
                            phi_d   = (b == 32'd0) ? a : w_ur;
                            plo_d   = (b == 32'd0) ? 32'hFFFF_FFFF : w_uq;
                            cnt_d   = C_DIV_CNT;
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // start is ignored here, including in the completion cycle
                if (cnt_q == C_CNT_ONE) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the pipelined core, beside the ALU.
- Consumes operand values after forwarding muxes (cw_fm_e1/cw_fm_e2 paths) plus an op code from pipeline control.
- Owns the architectural HI/LO registers.
- Exports busy so the hazard logic stalls any D-stage multiply/divide/HI/LO instruction while an operation is in flight.

Parameters:
- MULT_LATENCY, 5: cycles busy is held for MULT/MULTU (>=1).
- DIV_LATENCY, 10: cycles busy is held for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately when low.
- start  input  1  E-stage instruction is a multiply/divide or HI/LO write; sampled on the rising edge.
- op  input  3  operation, with these codes:
  - 0: none
  - 1: MULT
  - 2: MULTU
  - 3: DIV
  - 4: DIVU
  - 5: MTHI
  - 6: MTLO
  - 7: reserved, treated as none.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- busy  output  1  operation in flight; HI/LO not yet valid.
- hi  output  32  architectural HI, read by MFHI in E.
- lo  output  32  architectural LO, read by MFLO in E.

Behaviour:
- Reset (rst low, any time, including mid-operation):
  - busy=0, hi=0, lo=0, internal counter=0, pending result discarded.
  - Outputs change asynchronously.
- Idle accept: on a rising edge with start=1 and busy=0.
  - MULT/MULTU/DIV/DIVU:
    - Compute the 64-bit result from a,b sampled at that edge and hold it in pending_hi/pending_lo.
    - Load counter with MULT_LATENCY or DIV_LATENCY.
    - busy goes 1 after the edge.
  - MTHI: hi<=a at that edge. MTLO: lo<=a at that edge. busy stays 0 and nothing else changes.
  - op 0 or 7: no effect.
- Busy countdown:
  - Each edge while busy=1, counter decrements.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0 and counter<=0, all on the same edge.
  - Net effect: busy is high for exactly LATENCY cycles following the accepting edge.
  - With LATENCY=1, busy is high for one cycle.
- While busy=1:
  - hi/lo hold their old architectural values.
  - start is ignored and must not occur, because the hazard unit guarantees it. The bench flags start&&busy as an error.
- Start in the completion cycle: an edge where counter==1 and start=1 is still busy, so start is ignored. A new operation is accepted on the first edge with busy=0.
- Arithmetic:
  - MULT: signed 32x32 -> 64. hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed, quotient truncated toward zero. lo=quotient; hi=remainder with the sign of the dividend.
  - DIVU: unsigned. lo=quotient, hi=remainder.
  - Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=a.
  - DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- Implementation freedom:
  - The result may be computed combinationally at accept or iteratively during countdown.
  - The visible timing of busy/hi/lo must match the above exactly.
- The block has no flush input. Control never squashes an E-stage instruction after start has been asserted, so an accepted op always commits.

Test Plan:
- Reset then MULT a=32'hFFFFFFFE b=3 -> busy=1 for 5 cycles; hi/lo stay 0 during; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, busy=0.
- MULTU a=32'hFFFFFFFE b=3 -> after 5 cycles hi=32'h00000002, lo=32'hFFFFFFFA.
- DIV a=-7 (32'hFFFFFFF9) b=2 -> busy for 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=7 b=0 -> lo=32'hFFFFFFFF, hi=7.
- DIV a=32'h80000000 b=32'hFFFFFFFF -> lo=32'h80000000, hi=0. MTHI a=32'h12345678 -> hi=32'h12345678 on the next edge, busy never asserted.
- Back-to-back: MULT accepted, start held high with op=MTLO through busy -> start ignored until busy=0. MTLO is then accepted on the first idle edge, after MULT's lo is written, so the final lo is the MTLO value.
- Reset mid-operation: DIV accepted, rst low at cycle 4 for half a cycle -> busy, hi and lo go 0 immediately. After release, no late HI/LO update occurs.
